// File: rtl/mac_arbiter.sv
// Issue scheduler sharing one fixed-latency MAC datapath between two ports.
// Define MAC_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority (port 0 wins ties).
module mac_arbiter #(
  parameter int LAT = 4,
  parameter int W   = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic         req0_op,
  input  logic         req0_clr,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic         req1_op,
  input  logic         req1_clr,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         dp_valid,
  output logic         dp_op,
  output logic         dp_clr,
  output logic         dp_sel,
  output logic [W-1:0] dp_a,
  output logic [W-1:0] dp_b,
  input  logic         dp_done,
  input  logic [W-1:0] dp_res,
  output logic         rsp0_valid,
  output logic [W-1:0] rsp0_data,
  output logic         rsp1_valid,
  output logic [W-1:0] rsp1_data,
  output logic         busy,
  output logic         err
);

  logic [1:0] pend;
  logic       rr;
  logic [LAT:0] tag_v;
  logic [LAT:0] tag_p;
  logic [4:0] mask;

  logic elig0, elig1;
  logic gnt0, gnt1;
  logic hs0, hs1, hs;
  logic head_v, head_p;
  logic [1:0] pend_clr;

  // Ready is gated by rst so all outputs read 0 while reset is held.
  always_comb begin
    elig0 = req0_valid && !pend[0];
    elig1 = req1_valid && !pend[1];
    gnt0  = elig0 && (!elig1 || !rr);
    gnt1  = elig1 && (!elig0 || rr);
  end

  assign req0_ready = gnt0 && !rst;
  assign req1_ready = gnt1 && !rst;
  assign hs0 = req0_valid && req0_ready;
  assign hs1 = req1_valid && req1_ready;
  assign hs  = hs0 || hs1;

  assign head_v = tag_v[LAT];
  assign head_p = tag_p[LAT];

  always_comb begin
    pend_clr = 2'b00;
    if (head_v) begin
      if (head_p) pend_clr = 2'b10;
      else        pend_clr = 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dp_valid <= 1'b0;
      dp_op    <= 1'b0;
      dp_clr   <= 1'b0;
      dp_sel   <= 1'b0;
      dp_a     <= '0;
      dp_b     <= '0;
    end else begin
      dp_valid <= hs;
      if (hs0) begin
        dp_op  <= req0_op;
        dp_clr <= req0_clr;
        dp_sel <= 1'b0;
        dp_a   <= req0_a;
        dp_b   <= req0_b;
      end else if (hs1) begin
        dp_op  <= req1_op;
        dp_clr <= req1_clr;
        dp_sel <= 1'b1;
        dp_a   <= req1_a;
        dp_b   <= req1_b;
      end
    end
  end

  // Tag pipe: stage k holds the issue made k+1 cycles ago; the head lines up with dp_done.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v <= '0;
      tag_p <= '0;
    end else begin
      tag_v <= {tag_v[LAT-1:0], hs};
      tag_p <= {tag_p[LAT-1:0], hs1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= 2'b00;
    end else begin
      pend <= (pend & ~pend_clr) | {hs1, hs0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr <= 1'b0;
    end else begin
`ifdef MAC_ARB_RR_EN
      if (hs) rr <= hs0;
`else
      rr <= 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_data  <= '0;
      rsp1_data  <= '0;
    end else begin
      rsp0_valid <= head_v && !head_p;
      rsp1_valid <= head_v && head_p;
      if (head_v && !head_p) rsp0_data <= dp_res;
      if (head_v && head_p)  rsp1_data <= dp_res;
    end
  end

  // Completions still in the datapath from before reset are not flagged while mask counts down.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask <= 5'(LAT + 1);
    end else if (mask != 5'd0) begin
      mask <= mask - 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if ((head_v && !dp_done) || (!head_v && dp_done && mask == 5'd0)) begin
      err <= 1'b1;
    end
  end

  assign busy = |pend;

endmodule

// File: doc/mac_arbiter.md
# mac_arbiter

Issue scheduler that shares one fixed-latency floating-point MAC datapath (multiply → align/add → normalize → round) between two requester ports. Each port owns a separate accumulator bank inside the datapath, so each port may have at most one operation in flight at a time. The block arbitrates between the ports, registers the winning operands into the datapath, and tracks in-flight tags. It routes each result back to the port that issued it and flags any mismatch between expected and actual completions.

## Interface
- `LAT`, default 4: datapath latency in cycles, from `dp_valid` to `dp_done`; legal range 2..15.
- `W`, default 32: operand and result width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid` / `req1_valid`  in  1  request present.
- `req0_ready` / `req1_ready`  out  1  request accepted when valid && ready at a clock edge.
- `req0_op` / `req1_op`  in  1  precision: 0 = half, 1 = single.
- `req0_clr` / `req1_clr`  in  1  zero the port's accumulator before this MAC.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  W  operands.
- `dp_valid`  out  1  issue strobe to the datapath.
- `dp_op`  out  1  precision of the issued operation.
- `dp_clr`  out  1  clear flag of the issued operation.
- `dp_sel`  out  1  accumulator bank, equal to the issuing port index.
- `dp_a`, `dp_b`  out  W  issued operands.
- `dp_done`  in  1  datapath result strobe.
- `dp_res`  in  W  datapath result.
- `rsp0_valid` / `rsp1_valid`  out  1  one-cycle result pulse to the port.
- `rsp0_data` / `rsp1_data`  out  W  result; holds its value until the next response to that port.
- `busy`  out  1  high while any operation is pending.
- `err`  out  1  sticky protocol error flag.

## Operation
- State:
  - `pend[1:0]`: one-hot per port, operation in flight.
  - `rr`: priority pointer.
  - Tag pipe: LAT+1 stages of {valid, port}.
  - Post-reset mask counter.
- Eligibility: port i is eligible when `reqi_valid && !pend[i]`.
- Grant, combinational from state and valid:
  - Only one port eligible → that port is granted.
  - Both eligible → port `rr` is granted.
  - `reqi_ready` = granted to i; at most one ready is high per cycle.
- Valid-to-ready is a combinational path. Ready never depends on the other port's ready.
- On a handshake by port i:
  - Register op, clr, a, b and sel=i into the issue register.
  - Set `pend[i]`.
  - Push tag {1, i} into the tag pipe.
  - `rr` ← the other port (see Configuration).
- `dp_*` fields are valid only while `dp_valid` = 1. While `dp_valid` = 0 they hold their last value.
- Retire, when the tag-pipe head is valid with port p:
  - Sample `dp_done`/`dp_res`.
  - Register the result into `rspp_data`, pulse `rspp_valid`, and clear `pend[p]`.
- Error detection (sets `err`; only reset clears it):
  - Head valid while `dp_done` = 0.
  - `dp_done` = 1 while head invalid, once the mask counter is zero.
- On a missing `dp_done`: still retire, return `dp_res` as-is, and set `err`.
- Simultaneous retire and new request from the same port: the pend clear takes effect at the edge, so the port becomes eligible in the following cycle. No same-cycle bypass.
- `busy` = |pend.

## Timing
- Handshake at edge T → `dp_valid` high in cycle T+1 for exactly one cycle.
- `dp_done` is expected in cycle T+1+LAT.
- `rspi_valid` is high in cycle T+2+LAT.
- Earliest re-acceptance for the same port is cycle T+2+LAT. Per-port issue interval is LAT+2 cycles.
- Two ports alternating give up to 2 issues per LAT+2 cycles. Back-to-back issues from different ports are allowed on consecutive cycles.
- Reset values:
  - All outputs 0: ready, `dp_*`, `rsp*_valid`, `rsp*_data`, `busy`, `err`.
  - `pend` = 0, tag pipe cleared, `rr` = 0.
  - Mask counter = LAT+1.
- Reset mid-operation:
  - In-flight tags are discarded and no response is produced.
  - For the first LAT+1 cycles after `rst` deasserts, a stray `dp_done` is ignored and does not set `err`.

## Configuration
- `MAC_ARB_RR_EN` defined: round-robin arbitration. After each grant, `rr` moves to the non-granted port.
- `MAC_ARB_RR_EN` undefined: fixed priority. `rr` is held at 0, so port 0 wins every tie. All other behaviour is identical.

## Test plan
- Single request: LAT=4, port 0 issues op=1, a=0x3F800000, b=0x40000000 at edge T; datapath model returns 0x40000000 at T+5 → `dp_valid`/`dp_sel`=0 at T+1, `rsp0_valid` at T+6 with data 0x40000000, `busy` falls at T+6, `err`=0.
- Contention with `MAC_ARB_RR_EN`: both ports hold valid continuously → grant order 0,1, then 0 again at T+6; each port issues every 6 cycles.
- Same contention without the macro: port 0 wins every tie; port 1 is granted only while `pend[0]`=1.
- Back-pressure: port 0 holds valid with `pend[0]`=1 → `req0_ready`=0 until the cycle `rsp0_valid` is high; the next accept is at the following edge.
- Protocol error: suppress `dp_done` for one op → `err` sets in the retire cycle and stays 1; inject a stray `dp_done` with no in-flight op → `err`=1.
- Reset mid-flight: assert `rst` 2 cycles after issue → no `rsp*_valid`, `busy`=0; the late `dp_done` inside the mask window leaves `err`=0.
